// File: rtl/piano_key_debounce_if.sv
// Key-level bundle between the raw switch pins and the debounced key consumers.
// master: drives raw switches, observes clean levels/strobes (board / bench side).
// slave:  the debouncer itself.
interface piano_key_debounce_if #(
  parameter int NUM_KEYS = 3,
  parameter int IDX_W    = 2
);
  logic [NUM_KEYS-1:0] sw_raw;
  logic [NUM_KEYS-1:0] sw_clean;
  logic [NUM_KEYS-1:0] press_pulse;
  logic [NUM_KEYS-1:0] release_pulse;
  logic [IDX_W-1:0]    active_key;
  logic                key_valid;

  modport master (
    output sw_raw,
    input  sw_clean, press_pulse, release_pulse, active_key, key_valid
  );

  modport slave (
    input  sw_raw,
    output sw_clean, press_pulse, release_pulse, active_key, key_valid
  );
endinterface

// File: rtl/piano_key_debounce.sv
// Debounces raw piano key switches into clean levels for the note LUT, with
// press/release strobes and a lowest-index active-key encoder for mono playback.
//
// state  | meaning
// S_LOW  | key accepted released, waiting for a synced high sample
// S_RISE | counting consecutive high samples before accepting a press
// S_HIGH | key accepted pressed, waiting for a synced low sample
// S_FALL | counting consecutive low samples before accepting a release
module piano_key_debounce #(
  parameter int NUM_KEYS        = 3,
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int CNT_W           = 18,
  parameter int IDX_W           = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  piano_key_debounce_if.slave   key_if
);

  typedef enum logic [1:0] {S_LOW, S_RISE, S_HIGH, S_FALL} state_e;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [NUM_KEYS-1:0] s1_q, s2_q;
  state_e              state_q [NUM_KEYS];
  state_e              state_d [NUM_KEYS];
  logic [CNT_W-1:0]    cnt_q   [NUM_KEYS];
  logic [CNT_W-1:0]    cnt_d   [NUM_KEYS];
  logic [NUM_KEYS-1:0] clean_q, clean_d;
  logic [NUM_KEYS-1:0] press_q, press_d;
  logic [NUM_KEYS-1:0] rel_q, rel_d;
  logic [IDX_W-1:0]    act_q, act_d;
  logic                valid_q, valid_d;

  // Two-flop synchronizer for the asynchronous switch levels.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q <= '0;
      s2_q <= '0;
    end else begin
      s1_q <= key_if.sw_raw;
      s2_q <= s1_q;
    end
  end

  // Per-key FSM state and stability counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_KEYS; i++) begin
        state_q[i] <= S_LOW;
        cnt_q[i]   <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_KEYS; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
    end
  end

  // Next state, counter and registered outputs; a change in the synced level
  // during a count returns to the settled state without any strobe.
  always_comb begin
    clean_d = clean_q;
    press_d = '0;
    rel_d   = '0;
    for (int i = 0; i < NUM_KEYS; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      case (state_q[i])
        S_LOW: begin
          clean_d[i] = 1'b0;
          if (s2_q[i]) begin
            state_d[i] = S_RISE;
            cnt_d[i]   = CNT_ONE;
          end else begin
            cnt_d[i]   = '0;
          end
        end
        S_RISE: begin
          if (!s2_q[i]) begin
            state_d[i] = S_LOW;
            cnt_d[i]   = '0;
          end else if (cnt_q[i] == CNT_LAST) begin
            state_d[i] = S_HIGH;
            cnt_d[i]   = '0;
            clean_d[i] = 1'b1;
            press_d[i] = 1'b1;
          end else begin
            cnt_d[i]   = cnt_q[i] + CNT_ONE;
          end
        end
        S_HIGH: begin
          clean_d[i] = 1'b1;
          if (!s2_q[i]) begin
            state_d[i] = S_FALL;
            cnt_d[i]   = CNT_ONE;
          end
        end
        S_FALL: begin
          if (s2_q[i]) begin
            state_d[i] = S_HIGH;
            cnt_d[i]   = '0;
          end else if (cnt_q[i] == CNT_LAST) begin
            state_d[i] = S_LOW;
            cnt_d[i]   = '0;
            clean_d[i] = 1'b0;
            rel_d[i]   = 1'b1;
          end else begin
            cnt_d[i]   = cnt_q[i] + CNT_ONE;
          end
        end
        default: begin
          state_d[i] = S_LOW;
          cnt_d[i]   = '0;
          clean_d[i] = 1'b0;
        end
      endcase
    end
  end

  // Lowest-index priority encode of the next clean levels, so the index
  // lines up with sw_clean in the same cycle.
  always_comb begin
    act_d   = '0;
    valid_d = |clean_d;
    for (int i = NUM_KEYS - 1; i >= 0; i--) begin
      if (clean_d[i]) act_d = IDX_W'(i);
    end
  end

  // Output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clean_q <= '0;
      press_q <= '0;
      rel_q   <= '0;
      act_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      clean_q <= clean_d;
      press_q <= press_d;
      rel_q   <= rel_d;
      act_q   <= act_d;
      valid_q <= valid_d;
    end
  end

  assign key_if.sw_clean      = clean_q;
  assign key_if.press_pulse   = press_q;
  assign key_if.release_pulse = rel_q;
  assign key_if.active_key    = act_q;
  assign key_if.key_valid     = valid_q;

endmodule
